// File: rtl/cpu_pkg.sv
// Shared CPU definitions: instruction field positions, opcodes and the
// decoded control bundle handed from the decoder to the decode stage.
package cpu_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int ADDR_W_DEF = 4;

  localparam int OPC_HI = 31;
  localparam int OPC_LO = 27;
  localparam int RD_HI  = 26;
  localparam int RD_LO  = 23;
  localparam int RS1_HI = 22;
  localparam int RS1_LO = 19;
  localparam int RS2_HI = 18;
  localparam int RS2_LO = 15;
  localparam int IMM_HI = 14;
  localparam int IMM_LO = 0;

  typedef enum logic [4:0] {
    OP_NOP = 5'd0,
    OP_ADD = 5'd1,
    OP_SUB = 5'd2,
    OP_AND = 5'd3,
    OP_OR  = 5'd4,
    OP_LDD = 5'd5,
    OP_STD = 5'd6,
    OP_LDM = 5'd7
  } opcode_e;

  typedef struct packed {
    logic [3:0] op;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       use_rs1;
    logic       use_rs2;
  } ctrl_t;

endpackage

// File: rtl/control_decoder.sv
// Purely combinational opcode decode: control bits plus which source
// registers the instruction actually reads (drives hazard detection).
module control_decoder
  import cpu_pkg::*;
(
  input  logic [4:0] i_opcode,
  output ctrl_t      o_ctrl
);

  always_comb begin
    o_ctrl = '0;
    case (i_opcode)
      OP_ADD, OP_SUB, OP_AND, OP_OR: begin
        o_ctrl.op        = i_opcode[3:0];
        o_ctrl.reg_write = 1'b1;
        o_ctrl.use_rs1   = 1'b1;
        o_ctrl.use_rs2   = 1'b1;
      end
      OP_LDD: begin
        o_ctrl.op        = i_opcode[3:0];
        o_ctrl.reg_write = 1'b1;
        o_ctrl.mem_read  = 1'b1;
        o_ctrl.use_rs1   = 1'b1;
      end
      OP_STD: begin
        o_ctrl.op        = i_opcode[3:0];
        o_ctrl.mem_write = 1'b1;
        o_ctrl.use_rs1   = 1'b1;
        o_ctrl.use_rs2   = 1'b1;
      end
      OP_LDM: begin
        o_ctrl.op        = i_opcode[3:0];
        o_ctrl.reg_write = 1'b1;
      end
      // NOP and every undefined opcode fall through as an all-zero bundle
      default: o_ctrl = '0;
    endcase
  end

endmodule

// File: rtl/decode_stage.sv
// Decode stage: register-file addressing, load-use hazard stall, the ID/EX
// pipeline register and a saturating counter of load-use stall cycles.
module decode_stage
  import cpu_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     id_valid,
  input  logic [31:0]              id_instr,
  input  logic [31:0]              id_pc,
  input  logic                     flush,
  output logic [ADDR_W-1:0]        rd_addr1,
  output logic [ADDR_W-1:0]        rd_addr2,
  input  logic [DATA_W-1:0]        rd_data1,
  input  logic [DATA_W-1:0]        rd_data2,
  output logic                     stall,
  output logic                     ex_valid,
  output logic [3:0]               ex_op,
  output logic [ADDR_W-1:0]        ex_rd,
  output logic [ADDR_W-1:0]        ex_rs1,
  output logic [ADDR_W-1:0]        ex_rs2,
  output logic signed [DATA_W-1:0] ex_a,
  output logic signed [DATA_W-1:0] ex_b,
  output logic signed [DATA_W-1:0] ex_imm,
  output logic                     ex_reg_write,
  output logic                     ex_mem_read,
  output logic                     ex_mem_write,
  output logic [31:0]              ex_pc,
  output logic [15:0]              stall_count
);

  ctrl_t                     w_ctrl;
  logic [ADDR_W-1:0]         w_rd;
  logic [ADDR_W-1:0]         w_rs1;
  logic [ADDR_W-1:0]         w_rs2;
  logic signed [IMM_HI:0]    w_imm_raw;
  logic signed [DATA_W-1:0]  w_imm;
  logic                      w_hazard;

  logic                      r_vld_p1;
  logic [3:0]                r_op_p1;
  logic [ADDR_W-1:0]         r_rd_p1;
  logic [ADDR_W-1:0]         r_rs1_p1;
  logic [ADDR_W-1:0]         r_rs2_p1;
  logic signed [DATA_W-1:0]  r_a_p1;
  logic signed [DATA_W-1:0]  r_b_p1;
  logic signed [DATA_W-1:0]  r_imm_p1;
  logic [31:0]               r_pc_p1;
  logic                      r_reg_write_p1;
  logic                      r_mem_read_p1;
  logic                      r_mem_write_p1;
  logic [15:0]               r_stall_cnt_p1;

  control_decoder u_ctrl (
    .i_opcode (id_instr[OPC_HI:OPC_LO]),
    .o_ctrl   (w_ctrl)
  );

  assign w_rd      = ADDR_W'(id_instr[RD_HI:RD_LO]);
  assign w_rs1     = ADDR_W'(id_instr[RS1_HI:RS1_LO]);
  assign w_rs2     = ADDR_W'(id_instr[RS2_HI:RS2_LO]);
  assign w_imm_raw = id_instr[IMM_HI:IMM_LO];
  assign w_imm     = DATA_W'(w_imm_raw);

  assign rd_addr1 = w_rs1;
  assign rd_addr2 = w_rs2;

  // Only a load in EX needs a bubble; ALU results reach EX via forwarding
  assign w_hazard = (w_ctrl.use_rs1 && (r_rd_p1 == w_rs1)) ||
                    (w_ctrl.use_rs2 && (r_rd_p1 == w_rs2));
  assign stall    = id_valid && r_vld_p1 && r_mem_read_p1 && w_hazard && !flush;

  // ID -> EX boundary
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vld_p1       <= 1'b0;
      r_op_p1        <= '0;
      r_rd_p1        <= '0;
      r_rs1_p1       <= '0;
      r_rs2_p1       <= '0;
      r_a_p1         <= '0;
      r_b_p1         <= '0;
      r_imm_p1       <= '0;
      r_pc_p1        <= '0;
      r_reg_write_p1 <= 1'b0;
      r_mem_read_p1  <= 1'b0;
      r_mem_write_p1 <= 1'b0;
      r_stall_cnt_p1 <= '0;
    end else if (flush || stall) begin
      r_vld_p1       <= 1'b0;
      r_reg_write_p1 <= 1'b0;
      r_mem_read_p1  <= 1'b0;
      r_mem_write_p1 <= 1'b0;
      if (stall && (r_stall_cnt_p1 != 16'hFFFF))
        r_stall_cnt_p1 <= r_stall_cnt_p1 + 16'd1;
    end else begin
      r_vld_p1       <= id_valid;
      r_op_p1        <= w_ctrl.op;
      r_rd_p1        <= w_rd;
      r_rs1_p1       <= w_rs1;
      r_rs2_p1       <= w_rs2;
      r_a_p1         <= rd_data1;
      r_b_p1         <= rd_data2;
      r_imm_p1       <= w_imm;
      r_pc_p1        <= id_pc;
      r_reg_write_p1 <= id_valid && w_ctrl.reg_write;
      r_mem_read_p1  <= id_valid && w_ctrl.mem_read;
      r_mem_write_p1 <= id_valid && w_ctrl.mem_write;
    end
  end

  assign ex_valid     = r_vld_p1;
  assign ex_op        = r_op_p1;
  assign ex_rd        = r_rd_p1;
  assign ex_rs1       = r_rs1_p1;
  assign ex_rs2       = r_rs2_p1;
  assign ex_a         = r_a_p1;
  assign ex_b         = r_b_p1;
  assign ex_imm       = r_imm_p1;
  assign ex_pc        = r_pc_p1;
  assign ex_reg_write = r_reg_write_p1;
  assign ex_mem_read  = r_mem_read_p1;
  assign ex_mem_write = r_mem_write_p1;
  assign stall_count  = r_stall_cnt_p1;

endmodule
